// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low gate driver with independent rising/falling dead times.
// Optional fault latch (fault_i / fault_clr_i / fault_o) enabled by PWM_DEADTIME_FAULT_EN.
module pwm_deadtime_gen #(
  parameter int unsigned Resolution = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  pwm_i,
  input  logic [Resolution-1:0] deadtime_rise_i,
  input  logic [Resolution-1:0] deadtime_fall_i,
`ifdef PWM_DEADTIME_FAULT_EN
  input  logic                  fault_i,
  input  logic                  fault_clr_i,
  output logic                  fault_o,
`endif
  output logic                  pwm_h_o,
  output logic                  pwm_l_o,
  output logic                  dt_active_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLowOn,
    StDtRise,
    StHighOn,
    StDtFall
  } state_e;

  state_e                state_q, state_d;
  logic [Resolution-1:0] cnt_q, cnt_d;
  logic                  pwm_q;
  logic                  h_q, l_q, dt_q;
  logic                  h_d, l_d, dt_d;
  logic                  force_idle;

`ifdef PWM_DEADTIME_FAULT_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (fault_i) begin
      fault_d = 1'b1;
    end else if (fault_clr_i) begin
      fault_d = 1'b0;
    end
  end

  // The clearing edge itself still holds IDLE; the FSM resumes on the following edge.
  assign force_idle = fault_i | fault_q | ~enable_i;
  assign fault_o    = fault_q;
`else
  assign force_idle = ~enable_i;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (force_idle) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StLowOn: begin
          if (pwm_q) begin
            if (deadtime_rise_i == '0) begin
              state_d = StHighOn;
            end else begin
              state_d = StDtRise;
              cnt_d   = deadtime_rise_i - Resolution'(1);
            end
          end else begin
            state_d = StLowOn;
          end
        end
        StDtRise: begin
          if (!pwm_q) begin
            state_d = StLowOn;
          end else if (cnt_q == '0) begin
            state_d = StHighOn;
          end else begin
            cnt_d = cnt_q - Resolution'(1);
          end
        end
        StHighOn: begin
          if (!pwm_q) begin
            if (deadtime_fall_i == '0) begin
              state_d = StLowOn;
            end else begin
              state_d = StDtFall;
              cnt_d   = deadtime_fall_i - Resolution'(1);
            end
          end
        end
        StDtFall: begin
          if (pwm_q) begin
            state_d = StHighOn;
          end else if (cnt_q == '0) begin
            state_d = StLowOn;
          end else begin
            cnt_d = cnt_q - Resolution'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they switch on the same edge as the FSM.
  always_comb begin
    h_d  = (state_d == StHighOn);
    l_d  = (state_d == StLowOn);
    dt_d = (state_d == StDtRise) || (state_d == StDtFall);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pwm_q   <= 1'b0;
      h_q     <= 1'b0;
      l_q     <= 1'b0;
      dt_q    <= 1'b0;
`ifdef PWM_DEADTIME_FAULT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_i;
      h_q     <= h_d;
      l_q     <= l_d;
      dt_q    <= dt_d;
`ifdef PWM_DEADTIME_FAULT_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign pwm_h_o     = h_q;
  assign pwm_l_o     = l_q;
  assign dt_active_o = dt_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Randomized bench for pwm_deadtime_gen against a side/target/countdown reference model.
module tb_pwm_deadtime_gen;

  localparam int unsigned Resolution = 16;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  enable_i;
  logic                  pwm_i;
  logic [Resolution-1:0] deadtime_rise_i;
  logic [Resolution-1:0] deadtime_fall_i;
  logic                  pwm_h_o, pwm_l_o, dt_active_o;
`ifdef PWM_DEADTIME_FAULT_EN
  logic                  fault_o;
`endif

  pwm_deadtime_gen #(.Resolution(Resolution)) u_dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .enable_i       (enable_i),
    .pwm_i          (pwm_i),
    .deadtime_rise_i(deadtime_rise_i),
    .deadtime_fall_i(deadtime_fall_i),
`ifdef PWM_DEADTIME_FAULT_EN
    .fault_i        (1'b0),
    .fault_clr_i    (1'b0),
    .fault_o        (fault_o),
`endif
    .pwm_h_o        (pwm_h_o),
    .pwm_l_o        (pwm_l_o),
    .dt_active_o    (dt_active_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which side is driven (0 none, 1 low, 2 high), plus a pending
  // switch to 'target' after 'left' more edges of the same pwm level.
  int side, target, left;
  bit waiting, p_q;
  int h_run, last_h_run;

  function automatic void model_reset();
    side = 0; target = 0; left = 0; waiting = 0; p_q = 0;
  endfunction

  function automatic void model_edge();
    int desired, d;
    desired = p_q ? 2 : 1;
    if (!enable_i) begin
      side = 0; waiting = 0;
    end else if (waiting) begin
      if (desired != target) begin
        side = desired; waiting = 0;
      end else begin
        left--;
        if (left == 0) begin
          side = target; waiting = 0;
        end
      end
    end else if (side != desired) begin
      if (side == 0 && desired == 1) begin
        side = 1;
      end else begin
        d = (desired == 2) ? int'(deadtime_rise_i) : int'(deadtime_fall_i);
        if (d == 0) begin
          side = desired;
        end else begin
          side = 0; waiting = 1; target = desired; left = d;
        end
      end
    end
    p_q = pwm_i;
  endfunction

  task automatic compare_all();
    check_eq("pwm_h", pwm_h_o, (!waiting && side == 2));
    check_eq("pwm_l", pwm_l_o, (!waiting && side == 1));
    check_eq("dt_active", dt_active_o, waiting);
    check_eq("no_overlap", pwm_h_o & pwm_l_o, 0);
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    compare_all();
    if (pwm_h_o) h_run++;
    else if (h_run != 0) begin
      last_h_run = h_run;
      h_run = 0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset_pulse();
    #3 rst_ni = 1'b0;
    model_reset();
    #1;
    check_eq("rst_h", pwm_h_o, 0);
    check_eq("rst_l", pwm_l_o, 0);
    check_eq("rst_dt", dt_active_o, 0);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    int seg;
    model_reset();
    h_run = 0; last_h_run = 0;
    rst_ni = 1'b0; enable_i = 1'b0; pwm_i = 1'b0;
    deadtime_rise_i = '0; deadtime_fall_i = '0;
    #12;
    check_eq("reset_h", pwm_h_o, 0);
    check_eq("reset_l", pwm_l_o, 0);
    check_eq("reset_dt", dt_active_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    steps(2);

    // Square wave 20/20 with 3-cycle dead times.
    enable_i = 1'b1; deadtime_rise_i = 16'd3; deadtime_fall_i = 16'd3;
    steps(4);
    for (int k = 0; k < 3; k++) begin
      pwm_i = 1'b1;
      step();
      check_eq("l_still_on_1edge", pwm_l_o, 1);
      step();
      check_eq("l_off_2edges", pwm_l_o, 0);
      steps(18);
      pwm_i = 1'b0;
      steps(20);
    end
    check_eq("h_run_17", last_h_run, 17);

    // Zero dead time: pure complementary drive.
    deadtime_rise_i = '0; deadtime_fall_i = '0;
    for (int k = 0; k < 4; k++) begin
      pwm_i = ~pwm_i;
      steps(2);
      check_eq("h_follows_pwm", pwm_h_o, pwm_i);
      steps(5);
    end
    pwm_i = 1'b0;
    steps(3);

    // Pulse shorter than dead time is swallowed.
    deadtime_rise_i = 16'd5;
    pwm_i = 1'b1;
    steps(3);
    pwm_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("swallow_h", pwm_h_o, 0);
    end
    check_eq("swallow_l_back", pwm_l_o, 1);

    // Reset pulse mid DT_FALL with 4 counts remaining.
    deadtime_rise_i = 16'd1; deadtime_fall_i = 16'd8;
    pwm_i = 1'b1;
    steps(6);
    pwm_i = 1'b0;
    steps(6);
    check_eq("in_dt_fall", dt_active_o, 1);
    async_reset_pulse();
    step();
    check_eq("post_rst_low_on", pwm_l_o, 1);

    // Drop enable while HIGH_ON, re-enable with pwm high and D_rise=2.
    deadtime_rise_i = 16'd2;
    pwm_i = 1'b1;
    steps(6);
    check_eq("high_on", pwm_h_o, 1);
    enable_i = 1'b0;
    step();
    check_eq("dis_h", pwm_h_o, 0);
    check_eq("dis_l", pwm_l_o, 0);
    steps(2);
    enable_i = 1'b1;
    steps(2);
    check_eq("reen_dt", dt_active_o, 1);
    step();
    check_eq("reen_high", pwm_h_o, 1);

    // Randomized segments with occasional disables, dead-time changes and resets.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) deadtime_rise_i = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) deadtime_fall_i = 16'($urandom_range(0, 7));
      enable_i = ($urandom_range(0, 19) != 0);
      pwm_i    = 1'($urandom);
      seg      = $urandom_range(1, 12);
      for (int i = 0; i < seg; i++) begin
        step();
        if ($urandom_range(0, 7) == 0) deadtime_rise_i = 16'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 49) == 0) async_reset_pulse();
    end

    // One long dead time to exercise wide counter values.
    enable_i = 1'b1; pwm_i = 1'b0; deadtime_rise_i = 16'd300;
    steps(4);
    pwm_i = 1'b1;
    steps(305);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_gen.md
Name: pwm_deadtime_gen

Overview:
- Downstream stage of the heartbeat/standard PWM generators.
- Consumes a single-ended pwm_signal and produces a complementary high-side/low-side gate pair with independently programmable rising-edge and falling-edge dead times.
- Guarantees both outputs are never high together.
- Sits between the PWM mode logic and the chip pads.

Parameters:
- Resolution, 16, width of the dead-time values and the internal dead-time counter.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- enable_i  input  1  1 = run; 0 = force both outputs low
- pwm_i  input  1  single-ended PWM from the mode generator
- deadtime_rise_i  input  Resolution  cycles both outputs stay low on pwm 0->1 before pwm_h_o rises
- deadtime_fall_i  input  Resolution  cycles both outputs stay low on pwm 1->0 before pwm_l_o rises
- pwm_h_o  output  1  high-side drive (registered)
- pwm_l_o  output  1  low-side drive (registered)
- dt_active_o  output  1  1 while in a dead-time state (registered)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset (asynchronous, any time, including mid dead-time):
  - state=IDLE, pwm_q=0, cnt=0.
  - pwm_h_o=0, pwm_l_o=0, dt_active_o=0.
- Input stage: pwm_q <= pwm_i every edge. All FSM decisions use pwm_q only.
- Outputs are registers loaded with the next-state decode, so they are glitch-free and change on the same edge as the state.
- FSM states: IDLE, LOW_ON, DT_RISE, HIGH_ON, DT_FALL.
- Outputs per state (h, l, dt_active):
  - IDLE: 0, 0, 0
  - LOW_ON: 0, 1, 0
  - DT_RISE: 0, 0, 1
  - HIGH_ON: 1, 0, 0
  - DT_FALL: 0, 0, 1
- enable_i=0 in any state: next state IDLE; counter cleared. Has priority over all other transitions.
- IDLE, enable_i=1:
  - pwm_q=0 -> LOW_ON.
  - pwm_q=1 -> DT_RISE (or HIGH_ON if deadtime_rise_i==0).
- LOW_ON: pwm_q=1 -> DT_RISE with cnt <= deadtime_rise_i-1; if deadtime_rise_i==0, go directly to HIGH_ON.
- DT_RISE:
  - pwm_q=0 -> LOW_ON (abort: pulse shorter than dead time is swallowed; high side never turns on).
  - Else if cnt==0 -> HIGH_ON.
  - Else cnt <= cnt-1.
- HIGH_ON: pwm_q=0 -> DT_FALL with cnt <= deadtime_fall_i-1; if deadtime_fall_i==0, go directly to LOW_ON.
- DT_FALL: symmetric to DT_RISE.
  - pwm_q=1 -> HIGH_ON (abort).
  - Else if cnt==0 -> LOW_ON.
  - Else cnt <= cnt-1.
- Dead-time value handling:
  - Sampled only on the edge entering a DT state.
  - Changes during a count take effect at the next transition.
- Timing:
  - Both outputs are low for exactly D cycles, where D is the sampled dead time.
  - Latency from a pwm_i edge to the opposite-side turn-off is 2 clock edges (one input register, one FSM register).
  - Turn-on of the new side is 2+D edges after the pwm_i edge.
- Wrap-around: D=2^Resolution-1 is legal; the counter only decrements and never wraps.
- Invariant: pwm_h_o & pwm_l_o == 0 on every cycle, including reset release and enable toggling.

Optional Feature:
- Macro: PWM_DEADTIME_FAULT_EN.
- When defined, adds ports fault_i (input 1) and fault_clr_i (input 1), and output fault_o (output 1, registered, reset 0).
- fault_i=1 sets the fault latch:
  - Same edge: state=IDLE, outputs 0, fault_o=1.
  - Fault has priority over enable_i.
- The latch clears only on fault_clr_i=1 while fault_i=0. The FSM then resumes from IDLE.
- Simultaneous fault_i=1 and fault_clr_i=1: fault wins.
- When the macro is not defined: ports are absent and behaviour is as above.

Test Plan:
- D_rise=D_fall=3, enable=1, pwm_i square 20 cycles high / 20 low -> pwm_l_o falls 2 edges after pwm_i rises, both low 3 cycles, pwm_h_o high 17 cycles; mirrored on fall; h&l never both 1.
- D_rise=0, D_fall=0 -> pure complementary outputs; h toggles 2 edges after pwm_i; dt_active_o stays 0.
- D_rise=5, pwm_i high pulse of 3 cycles -> DT_RISE aborted, pwm_h_o never rises, pwm_l_o back high after 3 low cycles.
- Mid DT_FALL (D=8, cnt=4), rst_ni pulsed low asynchronously between edges -> outputs 0 immediately; after release with pwm_i=0 -> LOW_ON next edge.
- enable_i dropped while HIGH_ON -> both outputs 0 next edge; re-enable with pwm_i=1, D_rise=2 -> 2 cycles DT_RISE then HIGH_ON.
- (PWM_DEADTIME_FAULT_EN) fault_i pulse 1 cycle during HIGH_ON -> outputs 0, fault_o=1 held; fault_clr_i 1 cycle -> fault_o=0, IDLE -> LOW_ON next edge.
